// File: rtl/csr_access_unit_pkg.sv
// Shared types, constants and helpers for the CSR access unit.
package core_package;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned CSR_ADDR_W_DEF = 12;
  localparam int unsigned REG_IDX_W     = 5;

  // CSR instruction flavour as encoded on req_op_i
  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  // Privilege levels, ordered so that a numeric compare gives "at least"
  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_H = 2'b10,
    PRIV_M = 2'b11
  } priv_e;

  // User-visible counter CSRs gated by mcounteren
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  // Captured request payload (address kept separately, its width is a parameter)
  typedef struct packed {
    csr_op_e                op;
    logic                   imm;
    logic [XLEN-1:0]        rs1;
    logic [4:0]             uimm;
    logic                   src_zero;
    logic [REG_IDX_W-1:0]   rd;
  } csr_req_t;

  // Source operand: zero-extended immediate or rs1 value
  function automatic logic [XLEN-1:0] csr_operand(input logic imm,
                                                  input logic [4:0] uimm,
                                                  input logic [XLEN-1:0] rs1);
    return imm ? XLEN'(uimm) : rs1;
  endfunction

  // New CSR value produced by an operation on the old value
  function automatic logic [XLEN-1:0] csr_apply(input csr_op_e op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] src);
    logic [XLEN-1:0] res;
    case (op)
      CSR_OP_RW: res = src;
      CSR_OP_RS: res = old_val | src;
      CSR_OP_RC: res = old_val & ~src;
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake bundle between the pipeline and the CSR access unit.
interface csr_access_unit_if #(
  parameter int unsigned CSR_ADDR_W = 12
);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic                  req_imm_i;
  logic [CSR_ADDR_W-1:0] req_addr_i;
  logic [31:0]           req_rs1_data_i;
  logic [4:0]            req_uimm_i;
  logic                  req_src_zero_i;
  logic [4:0]            req_rd_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_rd_data_o;
  logic [4:0]            rsp_rd_o;
  logic                  rsp_illegal_o;

  // Pipeline side: issues requests, consumes responses
  modport master (
    output req_valid_i, req_op_i, req_imm_i, req_addr_i, req_rs1_data_i,
           req_uimm_i, req_src_zero_i, req_rd_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_rd_o, rsp_illegal_o
  );

  // Unit side: accepts requests, produces responses
  modport slave (
    input  req_valid_i, req_op_i, req_imm_i, req_addr_i, req_rs1_data_i,
           req_uimm_i, req_src_zero_i, req_rd_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_rd_o, rsp_illegal_o
  );

endinterface

// File: rtl/csr_access_check.sv
// Combinational legality and write-required decode for a captured CSR access.
module csr_access_check
  import core_package::*;
(
  input  csr_op_e     op,
  input  logic [11:0] addr,
  input  priv_e       priv,
  input  logic        src_zero,
  input  logic        cycle_en,
  input  logic        time_en,
  input  logic        instret_en,
  output logic        write_req_c,
  output logic        illegal_c
);

  logic [11:0] addr_fold;
  logic        counter_blocked;
  logic        priv_too_low;
  logic        ro_written;

  // Decode write intent, privilege, read-only and counter-enable violations
  always_comb begin
    write_req_c     = 1'b0;
    counter_blocked = 1'b0;
    addr_fold       = addr & ~12'h080;  // fold the high-half aliases (Cxx/C8x) together

    if (op == CSR_OP_RW) begin
      write_req_c = 1'b1;
    end else if (op != CSR_OP_RSVD) begin
      write_req_c = !src_zero;
    end

    priv_too_low = 2'(priv) < addr[9:8];
    ro_written   = (addr[11:10] == 2'b11) && write_req_c;

    if (priv == PRIV_U) begin
      case (addr_fold)
        CSR_CYCLE:   counter_blocked = !cycle_en;
        CSR_TIME:    counter_blocked = !time_en;
        CSR_INSTRET: counter_blocked = !instret_en;
        default:     counter_blocked = 1'b0;
      endcase
    end

    illegal_c = (op == CSR_OP_RSVD) || priv_too_low || ro_written || counter_blocked;
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR instruction: read old value, optionally write, return old value to rd.
module csr_access_unit
  import core_package::*;
#(
  parameter int unsigned CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  csr_access_unit_if.slave      bus,
  input  logic [1:0]            priv_i,
  input  logic                  cycle_en_i,
  input  logic                  time_en_i,
  input  logic                  instret_en_i,
  input  logic                  flush_i,
  output logic [CSR_ADDR_W-1:0] csr_addr_o,
  output logic [XLEN-1:0]       csr_w_data_o,
  output logic                  csr_w_en_o,
  input  logic [XLEN-1:0]       csr_data_i
);

  csr_state_e            state;
  csr_req_t              req_q;
  priv_e                 priv_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       old_q;
  logic                  ready_q;
  logic                  w_en_q;
  logic [XLEN-1:0]       w_data_q;
  logic                  rsp_valid_q;
  logic [XLEN-1:0]       rsp_data_q;
  logic [REG_IDX_W-1:0]  rsp_rd_q;
  logic                  rsp_ill_q;

  logic                  illegal_c;
  logic                  write_req_c;
  logic [XLEN-1:0]       operand_c;
  logic [XLEN-1:0]       new_val_c;

  csr_access_check u_check (
    .op          (req_q.op),
    .addr        (addr_q[11:0]),
    .priv        (priv_q),
    .src_zero    (req_q.src_zero),
    .cycle_en    (cycle_en_i),
    .time_en     (time_en_i),
    .instret_en  (instret_en_i),
    .write_req_c (write_req_c),
    .illegal_c   (illegal_c)
  );

  // Candidate write value, formed from the live read data while in READ
  always_comb begin
    operand_c = csr_operand(req_q.imm, req_q.uimm, req_q.rs1);
    new_val_c = csr_apply(req_q.op, csr_data_i, operand_c);
  end

  // Access sequencer with all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      priv_q      <= PRIV_U;
      addr_q      <= '0;
      old_q       <= '0;
      ready_q     <= 1'b1;
      w_en_q      <= 1'b0;
      w_data_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_ill_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            req_q   <= '{op:       csr_op_e'(bus.req_op_i),
                         imm:      bus.req_imm_i,
                         rs1:      bus.req_rs1_data_i,
                         uimm:     bus.req_uimm_i,
                         src_zero: bus.req_src_zero_i,
                         rd:       bus.req_rd_i};
            priv_q  <= priv_e'(priv_i);
            addr_q  <= bus.req_addr_i;
            ready_q <= 1'b0;
            state   <= ST_READ;
          end
        end

        ST_READ: begin
          old_q <= csr_data_i;
          if (flush_i) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end else if (!illegal_c && write_req_c) begin
            w_en_q   <= 1'b1;
            w_data_q <= new_val_c;
            state    <= ST_WRITE;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= illegal_c ? '0 : csr_data_i;
            rsp_ill_q   <= illegal_c;
            rsp_rd_q    <= req_q.rd;
            state       <= ST_RESP;
          end
        end

        ST_WRITE: begin
          // The write commits at this edge regardless of a flush
          w_en_q   <= 1'b0;
          w_data_q <= '0;
          if (flush_i) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= old_q;
            rsp_ill_q   <= 1'b0;
            rsp_rd_q    <= req_q.rd;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (flush_i || bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ill_q   <= 1'b0;
            rsp_rd_q    <= '0;
            ready_q     <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive registered state onto the ports
  assign bus.req_ready_o   = ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rd_data_o = rsp_data_q;
  assign bus.rsp_rd_o      = rsp_rd_q;
  assign bus.rsp_illegal_o = rsp_ill_q;
  assign csr_addr_o        = addr_q;
  assign csr_w_en_o        = w_en_q;
  assign csr_w_data_o      = w_data_q;

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-002 Parameter CSR_ADDR_W SHALL default to 12 and set the CSR address width.
REQ-003 req_valid_i  input  1  CSR instruction request valid.
REQ-004 req_ready_o  output  1  unit can accept a request.
REQ-005 req_op_i  input  2  operation: 01 RW, 10 RS, 11 RC, 00 reserved.
REQ-006 req_imm_i  input  1  1 selects the zero-extended req_uimm_i operand; 0 selects req_rs1_data_i.
REQ-007 req_addr_i  input  CSR_ADDR_W  CSR address.
REQ-008 req_rs1_data_i  input  32  rs1 operand.
REQ-009 req_uimm_i  input  5  immediate operand.
REQ-010 req_src_zero_i  input  1  rs1 index or uimm equals 0.
REQ-011 req_rd_i  input  5  destination register index.
REQ-012 priv_i  input  2  current privilege: 00 U, 11 M.
REQ-013 cycle_en_i, time_en_i, instret_en_i  input  1 each  mcounteren CY/TM/IR bits.
REQ-014 csr_addr_o  output  CSR_ADDR_W  address driven to the CSR register file.
REQ-015 csr_w_data_o  output  32  write data to the CSR file.
REQ-016 csr_w_en_o  output  1  CSR file write enable.
REQ-017 csr_data_i  input  32  combinational read data from the CSR file.
REQ-018 rsp_valid_o  output  1  response valid.
REQ-019 rsp_ready_i  input  1  consumer accepts the response.
REQ-020 rsp_rd_data_o  output  32  old CSR value for rd.
REQ-021 rsp_rd_o  output  5  destination index.
REQ-022 rsp_illegal_o  output  1  illegal-instruction flag.
REQ-023 flush_i  input  1  pipeline kill.

Function
REQ-024 The FSM SHALL have the states IDLE, READ, WRITE and RESP; req_ready_o SHALL equal (state==IDLE).
REQ-025 In IDLE, a cycle with req_valid_i=1 SHALL capture all req_* fields and priv_i into registers and move to READ.
REQ-026 In READ, csr_addr_o SHALL equal the captured address, csr_w_en_o SHALL be 0, and csr_data_i SHALL be latched as old_q.
REQ-027 Legality SHALL be evaluated in READ; an access SHALL be illegal if any of the following holds: op==00; priv < addr[9:8]; addr[11:10]==11 and a write is required; priv==U and addr is C00/C80 with cycle_en_i=0, C01/C81 with time_en_i=0, or C02/C82 with instret_en_i=0.
REQ-028 A write SHALL be required for RW always, and for RS/RC only when req_src_zero_i=0.
REQ-029 From READ, the FSM SHALL go to WRITE if the access is legal and a write is required, and to RESP otherwise.
REQ-030 In WRITE, csr_w_en_o SHALL be 1 for exactly one cycle with csr_w_data_o = op (RW), old_q|op (RS) or old_q&~op (RC), all 32-bit, then the FSM SHALL go to RESP.
REQ-031 In RESP, rsp_valid_o SHALL be 1 and held with stable data until rsp_ready_i=1; the FSM SHALL then return to IDLE.
REQ-032 rsp_rd_data_o SHALL be old_q, or 0 if illegal; rsp_illegal_o SHALL be 1 on an illegal access, and no write SHALL occur in that case.
REQ-033 Latency from the accept edge T SHALL be: rsp_valid_o at T+3 with a write, T+2 without.
REQ-034 csr_w_en_o SHALL be 0 whenever state!=WRITE; csr_w_data_o SHALL be 0 outside WRITE.
REQ-035 flush_i in READ or RESP SHALL return the FSM to IDLE next cycle with no write and no response; flush_i in WRITE SHALL let the write commit and then go to IDLE with no response; flush_i in IDLE SHALL be ignored.

Reset
REQ-036 reset_n=0 SHALL immediately force state to IDLE and set all outputs as follows: req_ready_o=1, csr_w_en_o=0, csr_w_data_o=0, csr_addr_o=0, rsp_valid_o=0, rsp_rd_data_o=0, rsp_rd_o=0, rsp_illegal_o=0.
REQ-037 A reset asserted in WRITE SHALL drop csr_w_en_o asynchronously, so that no write occurs at the following edge.

Structure
REQ-038 core_package SHALL hold csr_op_e, the FSM state enum, the priv_e levels and the counter CSR address constants.
REQ-039 Legality SHALL be implemented in one combinational sub-module, csr_access_check.

Verification
REQ-040 M-mode, RS to 0x300 with rs1=0x8 and old=0x1: one write of 0x9, then rsp_rd_data_o=0x1 at T+3.
REQ-041 RC with src_zero=1 to 0x305: no csr_w_en_o pulse, rsp at T+2 with the old value.
REQ-042 U-mode read of 0xC00 with cycle_en_i=0: rsp_illegal_o=1, rd_data=0, no write; the same access with cycle_en_i=1 is legal.
REQ-043 RW to read-only 0xF14 from M-mode: illegal, no write.
REQ-044 rsp_ready_i held low for 5 cycles: response stable, req_ready_o=0; reset_n pulsed low in WRITE: csr_w_en_o falls immediately, no write, FSM returns to IDLE.
